// File: rtl/alu_pkg.sv
// Shared constants for the EX-stage ALU control: ALUControl codes, funct fields,
// mul/div sequencer states and the single-cycle ALU decode.
package alu_pkg;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b100;
   localparam logic [2:0] ALU_MUL = 3'b101;
   localparam logic [2:0] ALU_SLT = 3'b110;

   localparam logic [1:0] OP_ADD   = 2'b00;
   localparam logic [1:0] OP_SUB   = 2'b01;
   localparam logic [1:0] OP_RTYPE = 2'b10;

   localparam logic [5:0] F_ADD   = 6'b100000;
   localparam logic [5:0] F_SUB   = 6'b100010;
   localparam logic [5:0] F_AND   = 6'b100100;
   localparam logic [5:0] F_OR    = 6'b100101;
   localparam logic [5:0] F_SLT   = 6'b101010;
   localparam logic [5:0] F_MUL   = 6'b011100;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MFLO  = 6'b010010;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_FIN  = 2'd2;

   // Single-cycle ALU select; anything not listed falls back to add.
   function automatic logic [2:0] alu_decode(input logic [1:0] alu_op, input logic [5:0] funct);
      logic [2:0] ctl;
      ctl = ALU_ADD;
      case (alu_op)
         OP_ADD: ctl = ALU_ADD;
         OP_SUB: ctl = ALU_SUB;
         OP_RTYPE: begin
            case (funct)
               F_ADD:   ctl = ALU_ADD;
               F_SUB:   ctl = ALU_SUB;
               F_AND:   ctl = ALU_AND;
               F_OR:    ctl = ALU_OR;
               F_SLT:   ctl = ALU_SLT;
               F_MUL:   ctl = ALU_MUL;
               default: ctl = ALU_ADD;
            endcase
         end
         default: ctl = ALU_ADD;
      endcase
      return ctl;
   endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider on operand magnitudes,
// with sign fix-up applied combinationally while in FIN.
module muldiv_iter
   import alu_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = $clog2(DATA_W) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic              flush_i,
   input  logic              div_i,
   input  logic              signed_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   output logic [1:0]        state_o,
   output logic              done_c,
   output logic [DATA_W-1:0] hi_c,
   output logic [DATA_W-1:0] lo_c
);

   logic [1:0]          state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   acc_q, acc_d;
   logic [DATA_W-1:0]   sh_q, sh_d;
   logic [DATA_W-1:0]   mcand_q, mcand_d;
   logic                is_div_q, is_div_d;
   logic                neg_quo_q, neg_quo_d;
   logic                neg_rem_q, neg_rem_d;

   logic                a_neg, b_neg, div_ge;
   logic [DATA_W-1:0]   a_mag, b_mag;
   logic [DATA_W:0]     mul_sum, div_shift;
   logic [2*DATA_W-1:0] prod, prod_fix;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      sh_d      = sh_q;
      mcand_d   = mcand_q;
      is_div_d  = is_div_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;

      a_neg     = signed_i & a_i[DATA_W-1];
      b_neg     = signed_i & b_i[DATA_W-1];
      a_mag     = a_neg ? -a_i : a_i;
      b_mag     = b_neg ? -b_i : b_i;
      mul_sum   = sh_q[0] ? ({1'b0, acc_q} + {1'b0, mcand_q}) : {1'b0, acc_q};
      div_shift = {acc_q, sh_q[DATA_W-1]};
      div_ge    = (div_shift >= {1'b0, mcand_q});

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               is_div_d = div_i;
               if (div_i && (b_i == '0)) begin
                  // Divide by zero: preload the final HI/LO pattern and skip RUN.
                  acc_d     = a_i;
                  sh_d      = '1;
                  mcand_d   = '0;
                  neg_quo_d = 1'b0;
                  neg_rem_d = 1'b0;
                  cnt_d     = '0;
                  state_d   = ST_FIN;
               end else begin
                  acc_d     = '0;
                  sh_d      = a_mag;
                  mcand_d   = b_mag;
                  neg_quo_d = a_neg ^ b_neg;
                  neg_rem_d = a_neg;
                  cnt_d     = CNT_W'(DATA_W);
                  state_d   = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            if (flush_i) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               if (is_div_q) begin
                  acc_d = div_ge ? DATA_W'(div_shift - {1'b0, mcand_q}) : div_shift[DATA_W-1:0];
                  sh_d  = {sh_q[DATA_W-2:0], div_ge};
               end else begin
                  acc_d = mul_sum[DATA_W:1];
                  sh_d  = {mul_sum[0], sh_q[DATA_W-1:1]};
               end
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_d = ST_FIN;
               end
            end
         end
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Result sign correction; only meaningful while in FIN.
   always_comb begin
      prod     = {acc_q, sh_q};
      prod_fix = neg_quo_q ? -prod : prod;
      if (is_div_q) begin
         hi_c = neg_rem_q ? -acc_q : acc_q;
         lo_c = neg_quo_q ? -sh_q : sh_q;
      end else begin
         hi_c = prod_fix[2*DATA_W-1:DATA_W];
         lo_c = prod_fix[DATA_W-1:0];
      end
      done_c  = (state_q == ST_FIN) & ~flush_i;
      state_o = state_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         sh_q      <= '0;
         mcand_q   <= '0;
         is_div_q  <= 1'b0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         sh_q      <= sh_d;
         mcand_q   <= mcand_d;
         is_div_q  <= is_div_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
      end
   end

endmodule

// File: rtl/alu_ctrl_seq.sv
// EX-stage ALU control: single-cycle decode, mul/div issue and stall,
// HI/LO registers and mfhi/mflo read-out.
module alu_ctrl_seq
   import alu_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = $clog2(DATA_W) + 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [5:0]        Funct,
   input  logic [1:0]        ALUOp,
   input  logic              Start,
   input  logic              Flush,
   input  logic [DATA_W-1:0] SrcA,
   input  logic [DATA_W-1:0] SrcB,
   output logic [2:0]        ALUControl,
   output logic              Stall,
   output logic              Done,
   output logic [DATA_W-1:0] HiLoOut
);

   logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
   logic [DATA_W-1:0] md_hi_c, md_lo_c;
   logic [1:0]        md_state;
   logic              md_done_c;
   logic              rtype, is_md, is_mfhi, is_mflo, issue_c;

   always_comb begin
      rtype   = (ALUOp == OP_RTYPE);
      is_md   = rtype & (Funct inside {F_MULT, F_MULTU, F_DIV, F_DIVU});
      is_mfhi = rtype & (Funct == F_MFHI);
      is_mflo = rtype & (Funct == F_MFLO);
      issue_c = Start & is_md & (md_state == ST_IDLE) & ~Flush;

      ALUControl = alu_decode(ALUOp, Funct);
      // A move behind an in-flight mul/div waits until HI/LO are written.
      Stall = issue_c | (md_state == ST_RUN) | (md_state == ST_FIN) |
              (Start & (is_mfhi | is_mflo) & (md_state != ST_IDLE));
      Done  = md_done_c;

      HiLoOut = '0;
      if (is_mfhi) begin
         HiLoOut = hi_q;
      end else if (is_mflo) begin
         HiLoOut = lo_q;
      end

      hi_d = hi_q;
      lo_d = lo_q;
      if (md_done_c) begin
         hi_d = md_hi_c;
         lo_d = md_lo_c;
      end
   end

   muldiv_iter #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) u_muldiv (
      .clk      (CLK),
      .rst      (RST),
      .start_i  (issue_c),
      .flush_i  (Flush),
      .div_i    (Funct[1]),
      .signed_i (~Funct[0]),
      .a_i      (SrcA),
      .b_i      (SrcB),
      .state_o  (md_state),
      .done_c   (md_done_c),
      .hi_c     (md_hi_c),
      .lo_c     (md_lo_c)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         hi_q <= '0;
         lo_q <= '0;
      end else begin
         hi_q <= hi_d;
         lo_q <= lo_d;
      end
   end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed-vector bench for alu_ctrl_seq: decode sweep, mul/div results and
// latency, divide-by-zero/overflow corners, flush/reset aborts, move interlock.
module tb_alu_ctrl_seq;

   logic        CLK = 1'b0;
   logic        RST;
   logic [5:0]  Funct;
   logic [1:0]  ALUOp;
   logic        Start;
   logic        Flush;
   logic [31:0] SrcA;
   logic [31:0] SrcB;
   logic [2:0]  ALUControl;
   logic        Stall;
   logic        Done;
   logic [31:0] HiLoOut;

   int n_chk = 0;
   int n_err = 0;

   alu_ctrl_seq #(.DATA_W(32)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .Funct      (Funct),
      .ALUOp      (ALUOp),
      .Start      (Start),
      .Flush      (Flush),
      .SrcA       (SrcA),
      .SrcB       (SrcB),
      .ALUControl (ALUControl),
      .Stall      (Stall),
      .Done       (Done),
      .HiLoOut    (HiLoOut)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic read_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
      Start = 1'b1;
      ALUOp = 2'b10;
      Funct = 6'b010000;
      #1;
      chk({tag, "_mfhi"}, 64'(HiLoOut), 64'(hi));
      Funct = 6'b010010;
      #1;
      chk({tag, "_mflo"}, 64'(HiLoOut), 64'(lo));
      Start = 1'b0;
      ALUOp = 2'b00;
      Funct = 6'b000000;
   endtask

   task automatic run_md(input string tag, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input int exp_lat,
                         input logic [31:0] hi, input logic [31:0] lo);
      int done_lat;
      int stall_n;
      tick();
      Start = 1'b1;
      ALUOp = 2'b10;
      Funct = f;
      SrcA  = a;
      SrcB  = b;
      #1;
      chk({tag, "_issue_stall"}, 64'(Stall), 64'(1));
      done_lat = 0;
      stall_n  = 0;
      for (int i = 1; i <= 100; i++) begin
         tick();
         Start = 1'b0;
         #1;
         if (Stall) stall_n++;
         if (Done) begin
            done_lat = i;
            break;
         end
      end
      chk({tag, "_lat"}, 64'(done_lat), 64'(exp_lat));
      chk({tag, "_stall_n"}, 64'(stall_n), 64'(exp_lat));
      tick();
      chk({tag, "_done_pulse"}, 64'(Done), 64'(0));
      chk({tag, "_stall_rel"}, 64'(Stall), 64'(0));
      read_hilo(tag, hi, lo);
   endtask

   task automatic abort_md(input string tag, input bit use_rst,
                           input logic [31:0] hi, input logic [31:0] lo);
      int dn;
      tick();
      Start = 1'b1;
      ALUOp = 2'b10;
      Funct = 6'b011000;
      SrcA  = 32'hFFFF_FFFF;
      SrcB  = 32'h0000_0002;
      for (int i = 1; i <= 9; i++) begin
         tick();
         Start = 1'b0;
      end
      tick();
      if (use_rst) RST = 1'b1;
      else Flush = 1'b1;
      #1;
      chk({tag, "_done_at_abort"}, 64'(Done), 64'(0));
      tick();
      RST   = 1'b0;
      Flush = 1'b0;
      #1;
      chk({tag, "_stall_after"}, 64'(Stall), 64'(0));
      chk({tag, "_done_after"}, 64'(Done), 64'(0));
      dn = 0;
      repeat (40) begin
         tick();
         if (Done) dn++;
      end
      chk({tag, "_no_done"}, 64'(dn), 64'(0));
      read_hilo(tag, hi, lo);
   endtask

   logic [5:0] fl   [13] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                             6'b011100, 6'b011000, 6'b011001, 6'b011010, 6'b011011,
                             6'b010000, 6'b010010, 6'b000000};
   logic [2:0] ex10 [13] = '{3'b010, 3'b100, 3'b000, 3'b001, 3'b110,
                             3'b101, 3'b010, 3'b010, 3'b010, 3'b010,
                             3'b010, 3'b010, 3'b010};

   initial begin
      int stall_n;
      bit seen;
      logic [2:0] exp_ctl;

      RST   = 1'b1;
      Start = 1'b0;
      Flush = 1'b0;
      ALUOp = 2'b00;
      Funct = 6'b000000;
      SrcA  = '0;
      SrcB  = '0;
      tick();
      chk("rst_stall", 64'(Stall), 64'(0));
      chk("rst_done", 64'(Done), 64'(0));
      tick();
      RST = 1'b0;
      tick();
      read_hilo("rst", 32'h0, 32'h0);

      for (int a = 0; a < 4; a++) begin
         ALUOp = 2'(a);
         for (int i = 0; i < 13; i++) begin
            Funct = fl[i];
            #1;
            case (a)
               0:       exp_ctl = 3'b010;
               1:       exp_ctl = 3'b100;
               2:       exp_ctl = ex10[i];
               default: exp_ctl = 3'b010;
            endcase
            chk($sformatf("dec_op%0d_f%0d", a, i), 64'(ALUControl), 64'(exp_ctl));
         end
      end
      ALUOp = 2'b00;
      Funct = 6'b000000;

      run_md("mult",     6'b011000, 32'hFFFF_FFFF, 32'h0000_0002, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      run_md("multu",    6'b011001, 32'hFFFF_FFFF, 32'h0000_0002, 33, 32'h0000_0001, 32'hFFFF_FFFE);
      run_md("mult_nn",  6'b011000, 32'hFFFF_FFF9, 32'hFFFF_FFFD, 33, 32'h0000_0000, 32'h0000_0015);
      run_md("div",      6'b011010, 32'hFFFF_FFF9, 32'h0000_0002, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_md("divu_big", 6'b011011, 32'hFFFF_FFFF, 32'h0000_0010, 33, 32'h0000_000F, 32'h0FFF_FFFF);
      run_md("div_ovf",  6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0000_0000, 32'h8000_0000);
      run_md("div_zero", 6'b011010, 32'h1234_5678, 32'h0000_0000, 1,  32'h1234_5678, 32'hFFFF_FFFF);
      run_md("divu",     6'b011011, 32'h0000_0007, 32'h0000_0002, 33, 32'h0000_0001, 32'h0000_0003);

      abort_md("flush", 1'b0, 32'h0000_0001, 32'h0000_0003);
      abort_md("rstmid", 1'b1, 32'h0000_0000, 32'h0000_0000);

      // Flush in the issue cycle suppresses the issue entirely.
      tick();
      Start = 1'b1;
      ALUOp = 2'b10;
      Funct = 6'b011001;
      SrcA  = 32'h0000_0003;
      SrcB  = 32'h0000_0003;
      Flush = 1'b1;
      #1;
      chk("flush_issue_stall", 64'(Stall), 64'(0));
      tick();
      Start = 1'b0;
      Flush = 1'b0;
      #1;
      chk("flush_issue_idle", 64'(Stall), 64'(0));

      // Dependent mflo right behind a mult.
      tick();
      Start = 1'b1;
      ALUOp = 2'b10;
      Funct = 6'b011000;
      SrcA  = 32'h0000_1234;
      SrcB  = 32'h0000_0100;
      tick();
      Funct = 6'b010010;
      #1;
      stall_n = 0;
      seen    = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (!Stall) break;
         stall_n++;
         if (Done) seen = 1'b1;
         tick();
         #1;
      end
      chk("dep_stall_n", 64'(stall_n), 64'(33));
      chk("dep_done_seen", 64'(seen), 64'(1));
      chk("dep_mflo", 64'(HiLoOut), 64'(32'h0012_3400));
      Start = 1'b0;

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
